spw_slot_pool: RTL and testbench

SPW_SLOT_POOL -- requirements
Module: spw_slot_pool

---
 rtl/spw_slot_pool_if.sv | 32 +++
 rtl/spw_slot_pool.sv | 91 +++++++++
 tb/tb_spw_slot_pool.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spw_slot_pool_if.sv
// Request/response bundle for the slot pool: allocation, read/release and status.
interface spw_slot_pool_if #(
   parameter int PTR_WIDTH  = 3,
   parameter int DATA_WIDTH = 128
);
   logic                  alloc_i;
   logic [DATA_WIDTH-1:0] write_data_i;
   logic                  alloc_valid_o;
   logic [PTR_WIDTH-1:0]  alloc_ptr_o;
   logic                  rd_req_i;
   logic [PTR_WIDTH-1:0]  rd_ptr_i;
   logic                  rd_release_i;
   logic                  rd_valid_o;
   logic [DATA_WIDTH-1:0] rd_data_o;
   logic [PTR_WIDTH:0]    count_o;
   logic                  full_o;
   logic                  empty_o;
   logic                  err_alloc_o;
   logic                  err_rd_o;

   modport slave (
      input  alloc_i, write_data_i, rd_req_i, rd_ptr_i, rd_release_i,
      output alloc_valid_o, alloc_ptr_o, rd_valid_o, rd_data_o,
             count_o, full_o, empty_o, err_alloc_o, err_rd_o
   );

   modport master (
      output alloc_i, write_data_i, rd_req_i, rd_ptr_i, rd_release_i,
      input  alloc_valid_o, alloc_ptr_o, rd_valid_o, rd_data_o,
             count_o, full_o, empty_o, err_alloc_o, err_rd_o
   );
endinterface

// File: rtl/spw_slot_pool.sv
// Lowest-free slot allocator with payload store; read data returns one cycle after rd_req_i.
// No backpressure: allocs while full and reads of free slots are dropped and flagged by err pulses.
module spw_slot_pool #(
   parameter int PTR_WIDTH  = 3,
   parameter int DATA_WIDTH = 128
) (
   input logic            clk_i,
   input logic            rst_i,
   spw_slot_pool_if.slave bus
);
   localparam int DEPTH = 1 << PTR_WIDTH;
   localparam int CW    = PTR_WIDTH + 1;

   logic [DEPTH-1:0]      valid_q, valid_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  rd_valid_q, rd_valid_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  err_alloc_q, err_alloc_d;
   logic                  err_rd_q, err_rd_d;
   logic [DATA_WIDTH-1:0] data_q [DEPTH];

   logic                  alloc_valid;
   logic [PTR_WIDTH-1:0]  alloc_ptr;
   logic                  alloc_ok;
   logic                  rd_hit;
   logic                  rel_ok;

   // Scan downward so the last match wins: lowest clear index, 0 when full.
   always_comb begin
      alloc_ptr = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) alloc_ptr = PTR_WIDTH'(i);
      end
   end

   assign alloc_valid = ~&valid_q;

   always_comb begin
      alloc_ok    = bus.alloc_i & alloc_valid;
      rd_hit      = bus.rd_req_i & valid_q[bus.rd_ptr_i];
      rel_ok      = rd_hit & bus.rd_release_i;

      // Alloc targets a free slot and release an occupied one, so they never collide.
      valid_d = valid_q;
      if (alloc_ok) valid_d[alloc_ptr]     = 1'b1;
      if (rel_ok)   valid_d[bus.rd_ptr_i]  = 1'b0;

      count_d     = count_q + CW'(alloc_ok) - CW'(rel_ok);
      rd_valid_d  = rd_hit;
      rd_data_d   = rd_hit ? data_q[bus.rd_ptr_i] : rd_data_q;
      err_alloc_d = bus.alloc_i & ~alloc_valid;
      err_rd_d    = bus.rd_req_i & ~rd_hit;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q     <= '0;
         count_q     <= '0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         err_alloc_q <= 1'b0;
         err_rd_q    <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         count_q     <= count_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         err_alloc_q <= err_alloc_d;
         err_rd_q    <= err_rd_d;
      end
   end

   // Payload storage carries no reset; occupancy alone decides what is readable.
   always_ff @(posedge clk_i) begin
      if (alloc_ok) data_q[alloc_ptr] <= bus.write_data_i;
   end

   assign bus.alloc_valid_o = alloc_valid;
   assign bus.alloc_ptr_o   = alloc_ptr;
   assign bus.count_o       = count_q;
   assign bus.full_o        = (count_q == CW'(DEPTH));
   assign bus.empty_o       = (count_q == '0);
   assign bus.rd_valid_o    = rd_valid_q;
   assign bus.rd_data_o     = rd_data_q;
   assign bus.err_alloc_o   = err_alloc_q;
   assign bus.err_rd_o      = err_rd_q;

   a_count_popcount : assert property (@(posedge clk_i) disable iff (rst_i)
      count_q == CW'($countones(valid_q)));

endmodule

// File: tb/tb_spw_slot_pool.sv
// Randomized and directed bench for spw_slot_pool against a free-list reference model.
module tb_spw_slot_pool;
   localparam int PW    = 3;
   localparam int DW    = 128;
   localparam int DEPTH = 1 << PW;

   logic clk;
   logic rst;

   spw_slot_pool_if #(.PTR_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

   spw_slot_pool #(.PTR_WIDTH(PW), .DATA_WIDTH(DW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Reference model: sorted free list, occupancy flags, stored payloads.
   int          free_q[$];
   bit          occ [DEPTH];
   logic [DW-1:0] mem [DEPTH];
   logic        exp_rd_valid;
   logic [DW-1:0] exp_rd_data;
   logic        exp_err_alloc;
   logic        exp_err_rd;

   function automatic void model_reset();
      free_q.delete();
      for (int i = 0; i < DEPTH; i++) begin
         free_q.push_back(i);
         occ[i] = 1'b0;
      end
      exp_rd_valid  = 1'b0;
      exp_rd_data   = '0;
      exp_err_alloc = 1'b0;
      exp_err_rd    = 1'b0;
   endfunction

   function automatic logic [PW:0] exp_count();
      return (PW + 1)'(DEPTH - free_q.size());
   endfunction

   function automatic logic [PW-1:0] exp_ptr();
      int v;
      v = (free_q.size() > 0) ? free_q[0] : 0;
      return PW'(v);
   endfunction

   task automatic drive_idle();
      bus.alloc_i      = 1'b0;
      bus.write_data_i = '0;
      bus.rd_req_i     = 1'b0;
      bus.rd_ptr_i     = '0;
      bus.rd_release_i = 1'b0;
   endtask

   // Applies one cycle of stimulus, advances the model, returns #1 after the edge.
   task automatic cyc(input logic a, input logic [DW-1:0] wd, input logic rq,
                      input logic [PW-1:0] rp, input logic rl);
      bit acc, hit;
      int slot;
      bus.alloc_i      = a;
      bus.write_data_i = wd;
      bus.rd_req_i     = rq;
      bus.rd_ptr_i     = rp;
      bus.rd_release_i = rl;
      acc = a && (free_q.size() > 0);
      hit = rq && occ[rp];
      exp_err_alloc = a && !acc;
      exp_err_rd    = rq && !hit;
      exp_rd_valid  = hit;
      if (hit) exp_rd_data = mem[rp];
      if (acc) begin
         slot = free_q.pop_front();
         mem[slot] = wd;
         occ[slot] = 1'b1;
      end
      if (hit && rl) begin
         occ[rp] = 1'b0;
         free_q.push_back(int'(rp));
         free_q.sort();
      end
      @(posedge clk);
      #1;
      drive_idle();
   endtask

   task automatic test_reset();
      vec_cnt++;
      if ({bus.count_o, bus.empty_o, bus.full_o, bus.alloc_valid_o, bus.alloc_ptr_o} !== {4'd0, 1'b1, 1'b0, 1'b1, 3'd0}) begin
         err_cnt++;
         $display("FAIL reset_status got cnt=%0d emp=%b full=%b av=%b ptr=%0d exp cnt=0 emp=1 full=0 av=1 ptr=0",
                  bus.count_o, bus.empty_o, bus.full_o, bus.alloc_valid_o, bus.alloc_ptr_o);
      end
      vec_cnt++;
      if ({bus.rd_valid_o, bus.err_alloc_o, bus.err_rd_o} !== 3'b000 || bus.rd_data_o !== '0) begin
         err_cnt++;
         $display("FAIL reset_outputs got rv=%b ea=%b er=%b rd=%h exp all zero",
                  bus.rd_valid_o, bus.err_alloc_o, bus.err_rd_o, bus.rd_data_o);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         vec_cnt++;
         if (bus.alloc_ptr_o !== PW'(i)) begin
            err_cnt++;
            $display("FAIL fill_ptr step=%0d got=%0d exp=%0d", i, bus.alloc_ptr_o, i);
         end
         cyc(1'b1, DW'(8'hA0 + i), 1'b0, '0, 1'b0);
      end
      vec_cnt++;
      if ({bus.count_o, bus.full_o, bus.alloc_valid_o, bus.empty_o} !== {4'd8, 1'b1, 1'b0, 1'b0}) begin
         err_cnt++;
         $display("FAIL fill_full got cnt=%0d full=%b av=%b emp=%b exp cnt=8 full=1 av=0 emp=0",
                  bus.count_o, bus.full_o, bus.alloc_valid_o, bus.empty_o);
      end
   endtask

   task automatic test_full_alloc();
      cyc(1'b1, DW'(16'hDEAD), 1'b0, '0, 1'b0);
      vec_cnt++;
      if ({bus.err_alloc_o, bus.count_o} !== {1'b1, 4'd8}) begin
         err_cnt++;
         $display("FAIL full_alloc_err got ea=%b cnt=%0d exp ea=1 cnt=8", bus.err_alloc_o, bus.count_o);
      end
      cyc(1'b0, '0, 1'b0, '0, 1'b0);
      vec_cnt++;
      if (bus.err_alloc_o !== 1'b0) begin
         err_cnt++;
         $display("FAIL full_alloc_pulse got ea=%b exp ea=0", bus.err_alloc_o);
      end
   endtask

   task automatic test_read_release();
      cyc(1'b0, '0, 1'b1, 3'd5, 1'b1);
      vec_cnt++;
      if ({bus.rd_valid_o, bus.count_o, bus.alloc_ptr_o} !== {1'b1, 4'd7, 3'd5} || bus.rd_data_o !== DW'(8'hA5)) begin
         err_cnt++;
         $display("FAIL rd_release got rv=%b rd=%h cnt=%0d ptr=%0d exp rv=1 rd=a5 cnt=7 ptr=5",
                  bus.rd_valid_o, bus.rd_data_o, bus.count_o, bus.alloc_ptr_o);
      end
      cyc(1'b0, '0, 1'b1, 3'd5, 1'b0);
      vec_cnt++;
      if ({bus.err_rd_o, bus.rd_valid_o} !== 2'b10 || bus.rd_data_o !== DW'(8'hA5)) begin
         err_cnt++;
         $display("FAIL rd_free got er=%b rv=%b rd=%h exp er=1 rv=0 rd=a5",
                  bus.err_rd_o, bus.rd_valid_o, bus.rd_data_o);
      end
      cyc(1'b0, '0, 1'b0, '0, 1'b0);
      vec_cnt++;
      if ({bus.err_rd_o, bus.rd_valid_o} !== 2'b00) begin
         err_cnt++;
         $display("FAIL rd_pulse got er=%b rv=%b exp er=0 rv=0", bus.err_rd_o, bus.rd_valid_o);
      end
      cyc(1'b1, DW'(8'hA5), 1'b0, '0, 1'b0);
   endtask

   task automatic test_full_alloc_release();
      cyc(1'b1, DW'(8'hEE), 1'b1, 3'd2, 1'b1);
      vec_cnt++;
      if ({bus.err_alloc_o, bus.count_o, bus.alloc_ptr_o, bus.rd_valid_o} !== {1'b1, 4'd7, 3'd2, 1'b1}
          || bus.rd_data_o !== DW'(8'hA2)) begin
         err_cnt++;
         $display("FAIL full_alloc_rel got ea=%b cnt=%0d ptr=%0d rv=%b rd=%h exp ea=1 cnt=7 ptr=2 rv=1 rd=a2",
                  bus.err_alloc_o, bus.count_o, bus.alloc_ptr_o, bus.rd_valid_o, bus.rd_data_o);
      end
   endtask

   task automatic test_alloc_and_release();
      cyc(1'b1, DW'(8'hA2), 1'b0, '0, 1'b0);
      cyc(1'b0, '0, 1'b1, 3'd3, 1'b1);
      vec_cnt++;
      if ({bus.count_o, bus.alloc_ptr_o} !== {4'd7, 3'd3}) begin
         err_cnt++;
         $display("FAIL setup_free3 got cnt=%0d ptr=%0d exp cnt=7 ptr=3", bus.count_o, bus.alloc_ptr_o);
      end
      cyc(1'b1, DW'(8'hB3), 1'b1, 3'd0, 1'b1);
      vec_cnt++;
      if ({bus.count_o, bus.alloc_ptr_o, bus.rd_valid_o} !== {4'd7, 3'd0, 1'b1} || bus.rd_data_o !== DW'(8'hA0)) begin
         err_cnt++;
         $display("FAIL alloc_rel_same got cnt=%0d ptr=%0d rv=%b rd=%h exp cnt=7 ptr=0 rv=1 rd=a0",
                  bus.count_o, bus.alloc_ptr_o, bus.rd_valid_o, bus.rd_data_o);
      end
      cyc(1'b0, '0, 1'b1, 3'd3, 1'b0);
      vec_cnt++;
      if (bus.rd_data_o !== DW'(8'hB3) || bus.count_o !== 4'd7) begin
         err_cnt++;
         $display("FAIL read_b3 got rd=%h cnt=%0d exp rd=b3 cnt=7", bus.rd_data_o, bus.count_o);
      end
   endtask

   task automatic test_random();
      logic [12:0] got, exp;
      int pa;
      for (int n = 0; n < 600; n++) begin
         pa = (n % 200 < 100) ? 75 : 25;
         cyc(($urandom_range(0, 99) < pa),
             {$urandom, $urandom, $urandom, $urandom},
             ($urandom_range(0, 99) < 60),
             PW'($urandom_range(0, DEPTH - 1)),
             ($urandom_range(0, 99) < (100 - pa)));
         got = {bus.alloc_valid_o, bus.alloc_ptr_o, bus.count_o, bus.full_o, bus.empty_o,
                bus.rd_valid_o, bus.err_alloc_o, bus.err_rd_o};
         exp = {(free_q.size() > 0), exp_ptr(), exp_count(), (free_q.size() == 0),
                (free_q.size() == DEPTH), exp_rd_valid, exp_err_alloc, exp_err_rd};
         vec_cnt++;
         if (got !== exp) begin
            err_cnt++;
            $display("FAIL rnd_status cyc=%0d got=%b exp=%b (av,ptr,cnt,full,emp,rv,ea,er)", n, got, exp);
         end
         vec_cnt++;
         if (bus.rd_data_o !== exp_rd_data) begin
            err_cnt++;
            $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", n, bus.rd_data_o, exp_rd_data);
         end
      end
   endtask

   task automatic test_reset_midstream();
      int slot;
      if (free_q.size() == DEPTH) cyc(1'b1, DW'(8'h55), 1'b0, '0, 1'b0);
      slot = 0;
      for (int i = DEPTH - 1; i >= 0; i--) if (occ[i]) slot = i;
      cyc(1'b0, '0, 1'b1, PW'(slot), 1'b0);
      vec_cnt++;
      if (bus.rd_valid_o !== 1'b1) begin
         err_cnt++;
         $display("FAIL mid_rd_pending got rv=%b exp rv=1", bus.rd_valid_o);
      end
      rst = 1'b1;
      model_reset();
      #1;
      vec_cnt++;
      if ({bus.rd_valid_o, bus.count_o, bus.empty_o, bus.alloc_ptr_o, bus.alloc_valid_o, bus.full_o}
          !== {1'b0, 4'd0, 1'b1, 3'd0, 1'b1, 1'b0}) begin
         err_cnt++;
         $display("FAIL mid_reset got rv=%b cnt=%0d emp=%b ptr=%0d av=%b full=%b exp rv=0 cnt=0 emp=1 ptr=0 av=1 full=0",
                  bus.rd_valid_o, bus.count_o, bus.empty_o, bus.alloc_ptr_o, bus.alloc_valid_o, bus.full_o);
      end
      @(posedge clk);
      #2;
      rst = 1'b0;
      cyc(1'b0, '0, 1'b1, '0, 1'b0);
      vec_cnt++;
      if ({bus.err_rd_o, bus.rd_valid_o, bus.count_o} !== {1'b1, 1'b0, 4'd0}) begin
         err_cnt++;
         $display("FAIL post_reset_rd got er=%b rv=%b cnt=%0d exp er=1 rv=0 cnt=0",
                  bus.err_rd_o, bus.rd_valid_o, bus.count_o);
      end
   endtask

   initial begin
      rst = 1'b1;
      drive_idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      test_fill();
      test_full_alloc();
      test_read_release();
      test_full_alloc_release();
      test_alloc_and_release();
      test_random();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
